instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Boot-time program loader/encoder: the inverse of the decode path. Accepts
//  assembly-level fields (class, regs, funct3, imm) over a valid/ready stream,
//  encodes each into an RV32I word (R/I/BEQ/JAL only, matching the decoder) and
//  writes it into instruction memory. Holds the core in reset until load completes.
// PARAMETERS
//  ADDR_W  10  imem byte-address width; capacity = 2**(ADDR_W-2) words
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       pulse: clear address, (re)begin load
//  in_valid      in   1       field bundle valid
//  in_ready      out  1       loader can accept bundle
//  in_class      in   2       00=R 01=I 10=B 11=J
//  in_rd/rs1/rs2 in   5 each  register indices
//  in_funct3     in   3       funct3
//  in_alt        in   1       R-type funct7[5] (SUB/SRA)
//  in_imm        in   21      signed immediate (byte offset for B/J)
//  in_last       in   1       final instruction of program
//  imem_wr_en    out  1       one-cycle write strobe
//  imem_addr     out  ADDR_W  byte address, word aligned
//  imem_wr_data  out  32      encoded instruction
//  cpu_hold      out  1       1 = keep core in reset
//  done / err    out  1 each  sticky status
// BEHAVIOUR
//  Reset: state IDLE, addr=0, in_ready=0, imem_wr_en=0, imem_wr_data=0,
//   cpu_hold=1, done=0, err=0. Reset mid-load aborts; memory is left partial.
//  FSM IDLE->ACCEPT on start. ACCEPT: in_ready=1; handshake = in_valid&in_ready
//   registers all fields -> ENCODE. ENCODE: word + legality check registered ->
//   WRITE (or ERR). WRITE: imem_wr_en=1 for exactly one cycle at imem_addr.
//   Then: in_last -> DONE; else addr+=4 -> ACCEPT.
//  Latency: handshake at cycle N -> imem_wr_en at N+2 -> in_ready again at N+3.
//  Encodings: R {0,alt,5'b0,rs2,rs1,f3,rd,0110011};
//   I {imm[11:0],rs1,f3,rd,0010011};
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011};
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
//  ERR conditions (checked in ENCODE, no write issued):
//   I: imm outside [-2048,2047], or f3 in {001,101}. R: alt=1 with f3 not
//   in {000,101}. B: f3!=000, imm[0]=1, or imm outside [-4096,4094].
//   J: imm[0]=1 (21-bit range implicit). Full: a non-last write would need
//   addr to wrap past the top word -> ERR; the top word itself is written.
//  DONE: done=1, cpu_hold=0. ERR: err=1, cpu_hold=1. Both hold until start/rst.
//  start in any state: addr=0, done=err=0, cpu_hold=1, -> ACCEPT next cycle;
//   start outranks a same-cycle handshake (bundle is not taken).
//  in_ready=0 in IDLE/ENCODE/WRITE/DONE/ERR; in_valid there is ignored.
// STRUCTURE
//  Opcodes, funct3 codes and the in_class enum live in the shared defines.svh
//  with the decoder constants (single source of truth); loader state enum is
//  local. Sub-module instr_encoder: combinational fields->{word,illegal}; the
//  top module owns the FSM, address counter and status flags.
// TESTING
//  addi x1,x0,1 (I,f3=000,rd=1,imm=1) -> word 0x00100093 at addr 0x000
//  add x3,x1,x2 then sub (alt=1) -> 0x002081B3 @0x004, 0x402081B3 @0x008
//  beq x1,x2,+8 -> 0x00208463; jal x1,-4 (last) -> 0xFFDFF0EF, done=1, cpu_hold=0
//  beq imm=3 or addi imm=2048 -> err=1, no imem_wr_en, cpu_hold stays 1
//  ADDR_W=4, 5 bundles, none last -> 4 writes @0x0..0xC, 5th -> err=1
//  rst asserted in WRITE -> all outputs at reset values same cycle; start reloads from 0x000

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared encoding constants and field bundle types for the boot-time program loader.
// Opcode and funct3 values match the decode path so both sides agree on one table.
package instr_mem_loader_pkg;

   typedef enum logic [1:0] {
      CLS_R = 2'b00,
      CLS_I = 2'b01,
      CLS_B = 2'b10,
      CLS_J = 2'b11
   } instr_class_e;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_BR  = 7'b1100011;
   localparam logic [6:0] OPC_JAL = 7'b1101111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam int IMM_W = 21;

   typedef struct packed {
      instr_class_e     cls;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [2:0]       funct3;
      logic             alt;
      logic [IMM_W-1:0] imm;
      logic             last;
   } fields_t;

   function automatic logic imm_in_range(input logic signed [IMM_W-1:0] v,
                                         input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/instr_mem_loader_encoder.sv
// Combinational field bundle -> RV32I word, plus a flag for bundles the decoder cannot represent.
module instr_encoder
   import instr_mem_loader_pkg::*;
(
   input  fields_t     fld,
   output logic [31:0] word,
   output logic        illegal
);

   logic signed [IMM_W-1:0] simm;
   assign simm = fld.imm;

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (fld.cls)
         CLS_R: begin
            word    = {1'b0, fld.alt, 5'b0, fld.rs2, fld.rs1, fld.funct3, fld.rd, OPC_R};
            // only ADD/SUB and SRL/SRA have an alternate form
            illegal = fld.alt && !((fld.funct3 == F3_ADD_SUB) || (fld.funct3 == F3_SRL_SRA));
         end
         CLS_I: begin
            word    = {fld.imm[11:0], fld.rs1, fld.funct3, fld.rd, OPC_I};
            illegal = !imm_in_range(simm, -2048, 2047) ||
                      (fld.funct3 == F3_SLL) || (fld.funct3 == F3_SRL_SRA);
         end
         CLS_B: begin
            word    = {fld.imm[12], fld.imm[10:5], fld.rs2, fld.rs1, fld.funct3,
                       fld.imm[4:1], fld.imm[11], OPC_BR};
            illegal = (fld.funct3 != F3_BEQ) || fld.imm[0] ||
                      !imm_in_range(simm, -4096, 4094);
         end
         CLS_J: begin
            word    = {fld.imm[20], fld.imm[10:1], fld.imm[11], fld.imm[19:12], fld.rd, OPC_JAL};
            illegal = fld.imm[0];
         end
         default: begin
            word    = '0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: takes field bundles over valid/ready, encodes and writes them to imem word by word,
// holding the core in reset until the last instruction lands (done) or a bundle is rejected (err).
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_class,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic [20:0]       in_imm,
   input  logic              in_last,
   output logic              imem_wr_en,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_ENCODE,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam logic [ADDR_W-1:0] TOP_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

   state_e            state;
   fields_t           fld;
   logic [ADDR_W-1:0] addr;
   logic              full;
   logic [31:0]       enc_word;
   logic              enc_illegal;

   assign imem_addr = addr;

   instr_encoder u_enc (
      .fld     (fld),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         fld          <= '0;
         addr         <= '0;
         full         <= 1'b0;
         in_ready     <= 1'b0;
         imem_wr_en   <= 1'b0;
         imem_wr_data <= '0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
      end else if (start) begin
         // restart wins over any bundle offered in the same cycle
         state      <= ST_ACCEPT;
         addr       <= '0;
         full       <= 1'b0;
         in_ready   <= 1'b1;
         imem_wr_en <= 1'b0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_ACCEPT: begin
               if (in_valid && in_ready) begin
                  fld.cls    <= instr_class_e'(in_class);
                  fld.rd     <= in_rd;
                  fld.rs1    <= in_rs1;
                  fld.rs2    <= in_rs2;
                  fld.funct3 <= in_funct3;
                  fld.alt    <= in_alt;
                  fld.imm    <= in_imm;
                  fld.last   <= in_last;
                  in_ready   <= 1'b0;
                  state      <= ST_ENCODE;
               end
            end
            ST_ENCODE: begin
               // full means the previous write already used the top word
               if (enc_illegal || full) begin
                  err   <= 1'b1;
                  state <= ST_ERR;
               end else begin
                  imem_wr_data <= enc_word;
                  imem_wr_en   <= 1'b1;
                  state        <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               imem_wr_en <= 1'b0;
               if (fld.last) begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= ST_DONE;
               end else begin
                  if (addr == TOP_ADDR) begin
                     full <= 1'b1;
                  end else begin
                     addr <= addr + ADDR_W'(4);
                  end
                  in_ready <= 1'b1;
                  state    <= ST_ACCEPT;
               end
            end
            default: begin
               // IDLE, DONE and ERR wait for start
               in_ready   <= 1'b0;
               imem_wr_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
